regfile_scoreboard: RTL and testbench

//  Parametrised multi-port CPU register file with an integrated pending-write scoreboard.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/regfile_scoreboard_if.sv | 25 ++
 rtl/rf_read_port.sv | 28 ++
 rtl/regfile_scoreboard.sv | 59 +++++
 tb/tb_regfile_scoreboard.sv | 112 +++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file geometry and index type shared with decode and ALU
package cpu_pkg;
  localparam int DATA_W = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int ZERO_REG = 31;
  typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, writeback and issue signals between pipeline and register file
interface regfile_scoreboard_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int NUM_RD = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0] rd_ready;
  logic w0_en, w1_en;
  logic [ADDR_W-1:0] w0_addr, w1_addr;
  logic [DATA_W-1:0] w0_data, w1_data;
  logic issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [NUM_REGS-1:0] busy_vec;
  modport master (
    output rd_addr, w0_en, w1_en, w0_addr, w1_addr, w0_data, w1_data, issue_en, issue_addr,
    input rd_data, rd_ready, busy_vec
  );
  modport slave (
    input rd_addr, w0_en, w1_en, w0_addr, w1_addr, w0_data, w1_data, issue_en, issue_addr,
    output rd_data, rd_ready, busy_vec
  );
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with write bypass, zero-register force and readiness
module rf_read_port #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic [DATA_W-1:0] regs_i [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic w0_en_i,
  input  logic [ADDR_W-1:0] w0_addr_i,
  input  logic [DATA_W-1:0] w0_data_i,
  input  logic w1_en_i,
  input  logic [ADDR_W-1:0] w1_addr_i,
  input  logic [DATA_W-1:0] w1_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic ready_o
);
  logic hit0, hit1, zero;
  always_comb begin
    hit0 = w0_en_i && (w0_addr_i == addr_i);
    hit1 = w1_en_i && (w1_addr_i == addr_i);
    zero = 32'(addr_i) == ZERO_REG;
    data_o = zero ? '0 : hit1 ? w1_data_i : hit0 ? w0_data_i : regs_i[addr_i];
    ready_o = ~busy_i[addr_i] | hit0 | hit1 | zero;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with two write ports and per-register pending-write tracking
module regfile_scoreboard #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
  input logic clk_i,
  input logic rst_ni,
  regfile_scoreboard_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic w0_ok, w1_ok, iss_ok, dbl_issue;
  always_comb begin
    w0_ok = bus.w0_en && (32'(bus.w0_addr) != ZERO_REG);
    w1_ok = bus.w1_en && (32'(bus.w1_addr) != ZERO_REG);
    iss_ok = bus.issue_en && (32'(bus.issue_addr) != ZERO_REG);
    dbl_issue = iss_ok && busy_q[bus.issue_addr]
      && !(w0_ok && bus.w0_addr == bus.issue_addr) && !(w1_ok && bus.w1_addr == bus.issue_addr);
  end
  // port 1 is assigned last so it wins an address collision
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (w0_ok) regs_q[bus.w0_addr] <= bus.w0_data;
      if (w1_ok) regs_q[bus.w1_addr] <= bus.w1_data;
    end
  end
  // a fresh issue supersedes a completing write to the same register
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      busy_d[i] = (iss_ok && 32'(bus.issue_addr) == i)
        | (busy_q[i] & ~(w0_ok && 32'(bus.w0_addr) == i) & ~(w1_ok && 32'(bus.w1_addr) == i));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign bus.busy_vec = busy_q;
  no_double_issue: assert property (@(posedge clk_i) disable iff (!rst_ni) !dbl_issue);
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_rd (
      .regs_i(regs_q),
      .busy_i(busy_q),
      .addr_i(bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .w0_en_i(bus.w0_en),
      .w0_addr_i(bus.w0_addr),
      .w0_data_i(bus.w0_data),
      .w1_en_i(bus.w1_en),
      .w1_addr_i(bus.w1_addr),
      .w1_data_i(bus.w1_data),
      .data_o(bus.rd_data[k*DATA_W +: DATA_W]),
      .ready_o(bus.rd_ready[k])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus a random issue/write soak against an array model
module tb_regfile_scoreboard;
  import cpu_pkg::*;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  logic [63:0] mdl [32];
  logic [31:0] mbusy;
  regfile_scoreboard_if #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2)) bus ();
  regfile_scoreboard #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(31)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mbusy = '0;
  endtask
  task automatic idle(input reg_idx_t r0, input reg_idx_t r1);
    bus.w0_en = 0; bus.w1_en = 0; bus.issue_en = 0;
    bus.w0_addr = '0; bus.w1_addr = '0; bus.issue_addr = '0;
    bus.w0_data = '0; bus.w1_data = '0;
    bus.rd_addr = {r1, r0};
  endtask
  task automatic step(input logic w0e, input reg_idx_t w0a, input logic [63:0] w0d,
                      input logic w1e, input reg_idx_t w1a, input logic [63:0] w1d,
                      input logic ie, input reg_idx_t ia, input reg_idx_t r0, input reg_idx_t r1);
    reg_idx_t a;
    logic [63:0] ed;
    logic er;
    bus.w0_en = w0e; bus.w0_addr = w0a; bus.w0_data = w0d;
    bus.w1_en = w1e; bus.w1_addr = w1a; bus.w1_data = w1d;
    bus.issue_en = ie; bus.issue_addr = ia;
    bus.rd_addr = {r1, r0};
    #1;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? r0 : r1;
      ed = (a == 31) ? 64'd0 : (w1e && w1a == a) ? w1d : (w0e && w0a == a) ? w0d : mdl[a];
      er = (a == 31) || !mbusy[a] || (w0e && w0a == a) || (w1e && w1a == a);
      chk($sformatf("rd%0d_data_r%0d", k, a), bus.rd_data[k*64 +: 64], ed);
      chk($sformatf("rd%0d_ready_r%0d", k, a), 64'(bus.rd_ready[k]), 64'(er));
    end
    chk("busy_vec", 64'(bus.busy_vec), 64'(mbusy));
    @(posedge clk);
    if (w0e && w0a != 31) mdl[w0a] = w0d;
    if (w1e && w1a != 31) mdl[w1a] = w1d;
    if (w0e) mbusy[w0a] = 0;
    if (w1e) mbusy[w1a] = 0;
    if (ie && ia != 31) mbusy[ia] = 1;
    @(negedge clk);
  endtask
  initial begin
    logic w0e, w1e, ie;
    reg_idx_t w0a, w1a, ia;
    int hi;
    rst_n = 0;
    idle(5, 5);
    bus.w0_en = 1; bus.w0_addr = 5; bus.w0_data = 64'hDEAD;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle(5, 5);
    #1;
    chk("rst_rd0", bus.rd_data[63:0], 64'd0);
    chk("rst_rd1", bus.rd_data[127:64], 64'd0);
    chk("rst_busy", 64'(bus.busy_vec), 64'd0);
    chk("rst_ready", 64'(bus.rd_ready), 64'd3);
    rst_n = 1;
    @(negedge clk);
    step(1, 5, 64'hDEAD, 0, 0, 0, 1, 6, 5, 6);
    idle(5, 6);
    rst_n = 0;
    #1;
    chk("async_rst_r5", bus.rd_data[63:0], 64'd0);
    chk("async_rst_busy", 64'(bus.busy_vec), 64'd0);
    chk("async_rst_ready", 64'(bus.rd_ready), 64'd3);
    model_reset();
    rst_n = 1;
    @(negedge clk);
    step(1, 3, 64'h1234, 0, 0, 0, 0, 0, 3, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    step(1, 3, 64'h5678, 0, 0, 0, 0, 0, 3, 3);
    step(1, 7, 64'hAAAA, 1, 7, 64'hBBBB, 0, 0, 7, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 3);
    step(1, 31, 64'hFFFF, 0, 0, 0, 1, 31, 31, 31);
    step(0, 0, 0, 0, 0, 0, 0, 0, 31, 31);
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 4, 4);
    step(0, 0, 0, 1, 4, 64'h42, 0, 0, 4, 4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 4, 4);
    step(1, 9, 64'h99, 0, 0, 0, 1, 9, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    for (int i = 0; i < 400; i++) begin
      hi = (i % 3 == 0) ? 31 : 7;
      w0e = 1'($urandom); w1e = 1'($urandom); ie = 1'($urandom);
      w0a = reg_idx_t'($urandom_range(0, hi));
      w1a = reg_idx_t'($urandom_range(0, hi));
      ia = reg_idx_t'($urandom_range(0, hi));
      if (mbusy[ia] && !(w0e && w0a == ia) && !(w1e && w1a == ia)) ie = 0;
      step(w0e, w0a, {$urandom, $urandom}, w1e, w1a, {$urandom, $urandom}, ie, ia,
           reg_idx_t'($urandom_range(0, hi)), reg_idx_t'($urandom_range(0, hi)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
